// File: rtl/pipe_pkg.sv
// Shared handshake and payload types for the elastic
// stage-boundary registers between core pipeline stages.
package pipe_pkg;

  typedef struct packed {
    logic valid;
    logic ready;
  } pipe_hs_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fd_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [5:0]  alu_op;
  } dx_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [31:0] store_data;
    logic        mem_we;
    logic        mem_re;
  } xm_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] wb_data;
    logic        wb_en;
  } mw_t;

  // Counts 0..DEPTH stages plus the optional skid entry.
  function automatic int occ_w(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid register that absorbs the beat accepted while
// the chain head is stalled, so ready_o can come from a flop.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q;
  logic             valid_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (push_i) begin
      valid_d = 1'b1;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      if (push_i) begin
        data_q <= data_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/elastic_pipe_reg.sv
// Elastic valid/ready register chain with bubble collapse, flush,
// optional registered-ready skid entry and a saturating stall count.
module elastic_pipe_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 1,
  parameter int REG_READY = 0,
  parameter int CNT_W     = 16,
  localparam int OCC_W    = occ_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [OCC_W-1:0] occupancy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] up_v;
  logic [WIDTH-1:0] d_q  [DEPTH];
  logic [WIDTH-1:0] up_d [DEPTH];

  logic             src_v;
  logic [WIDTH-1:0] src_d;
  logic             in_fire;
  logic             out_fire;
  pipe_hs_t         in_hs;
  pipe_hs_t         out_hs;

  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] stall_d;

  assign in_hs    = '{valid: valid_i, ready: ready_o};
  assign out_hs   = '{valid: v_q[DEPTH-1], ready: ready_i};
  assign in_fire  = in_hs.valid & in_hs.ready;
  assign out_fire = out_hs.valid & out_hs.ready;

  // A stage advances if the consumer takes data or any stage
  // at or downstream of it is empty.
  always_comb begin
    adv = '0;
    for (int k = 0; k < DEPTH; k++) begin
      adv[k] = ready_i;
      for (int j = k; j < DEPTH; j++) begin
        if (!v_q[j]) begin
          adv[k] = 1'b1;
        end
      end
    end
  end

  if (REG_READY != 0) begin : g_skid
    logic             skid_v;
    logic [WIDTH-1:0] skid_d;

    pipe_skid_buf #(
      .WIDTH(WIDTH)
    ) u_skid (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .flush_i(flush_i),
      .push_i (in_fire & ~adv[0]),
      .pop_i  (adv[0]),
      .data_i (data_i),
      .valid_o(skid_v),
      .data_o (skid_d)
    );

    assign ready_o = ~skid_v;
    assign src_v   = skid_v | in_fire;
    assign src_d   = skid_v ? skid_d : data_i;
  end else begin : g_comb
    assign ready_o = adv[0];
    assign src_v   = valid_i;
    assign src_d   = data_i;
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign up_v[k] = src_v;
      assign up_d[k] = src_d;
    end else begin : g_body
      assign up_v[k] = v_q[k-1];
      assign up_d[k] = d_q[k-1];
    end
    assign v_d[k] = flush_i ? 1'b0 : (adv[k] ? up_v[k] : v_q[k]);
  end

  always_comb begin
    occ_d = occ_q;
    if (flush_i) begin
      occ_d = '0;
    end else if (in_fire && !out_fire) begin
      occ_d = occ_q + 1'b1;
    end else if (!in_fire && out_fire) begin
      occ_d = occ_q - 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (out_hs.valid && !out_hs.ready && !flush_i && !(&stall_q)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v_q     <= '0;
      occ_q   <= '0;
      stall_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= '0;
      end
    end else begin
      v_q     <= v_d;
      occ_q   <= occ_d;
      stall_q <= stall_d;
      for (int k = 0; k < DEPTH; k++) begin
        if (adv[k]) begin
          d_q[k] <= up_d[k];
        end
      end
    end
  end

  assign valid_o     = v_q[DEPTH-1];
  assign data_o      = d_q[DEPTH-1];
  assign occupancy_o = occ_q;
  assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Bench for elastic_pipe_reg: four parameter corners share one
// stimulus stream; a timestamped queue model predicts every output.
module tb_elastic_pipe_reg;

  localparam int NI = 4;

  function automatic int dep_of(input int g);
    case (g)
      0: return 3;
      1: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int rr_of(input int g);
    return (g == 1 || g == 2) ? 1 : 0;
  endfunction

  function automatic int cw_of(input int g);
    return (g == 1) ? 3 : 16;
  endfunction

  logic        clk;
  logic        rst;
  logic        flush;
  logic        vin;
  logic        rin;
  logic [15:0] din;

  logic        rdy  [NI];
  logic        vo   [NI];
  logic [15:0] dout [NI];
  logic [3:0]  occ  [NI];
  logic [15:0] stl  [NI];

  int nrun;
  int nfail;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int D  = dep_of(g);
    localparam int CW = cw_of(g);
    logic [$clog2(D+2)-1:0] occ_l;
    logic [CW-1:0]          stl_l;

    elastic_pipe_reg #(
      .WIDTH    (16),
      .DEPTH    (D),
      .REG_READY(rr_of(g)),
      .CNT_W    (CW)
    ) u_dut (
      .clk_i      (clk),
      .reset_i    (rst),
      .flush_i    (flush),
      .valid_i    (vin),
      .ready_o    (rdy[g]),
      .data_i     (din),
      .valid_o    (vo[g]),
      .ready_i    (rin),
      .data_o     (dout[g]),
      .occupancy_o(occ_l),
      .stall_cnt_o(stl_l)
    );

    assign occ[g] = 4'(occ_l);
    assign stl[g] = 16'(stl_l);

    a_hold: assert property (@(posedge clk) disable iff (rst)
      (vo[g] && !rin && !flush) |=> (vo[g] && $stable(dout[g])));
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: in-order queue of accepted beats, each stamped with the
  // edge it entered stage 0 (-1 while parked in the skid entry).
  logic [15:0] md [NI][8];
  int          mt [NI][8];
  int          mh [NI];
  int          ms [NI];
  int          mch[NI];
  int          mst[NI];
  int          edge_n;

  function automatic int m_tail(input int g);
    return (mh[g] + ms[g] - 1) % 8;
  endfunction

  function automatic bit m_skid(input int g);
    return ms[g] > 0 && mt[g][m_tail(g)] < 0;
  endfunction

  function automatic bit m_vo(input int g);
    if (ms[g] == 0 || mt[g][mh[g]] < 0) return 1'b0;
    return edge_n >= mt[g][mh[g]] + dep_of(g) - 1;
  endfunction

  function automatic bit m_rdy(input int g);
    if (rr_of(g) != 0) return !m_skid(g);
    return (mch[g] < dep_of(g)) || rin;
  endfunction

  task automatic m_reset();
    for (int g = 0; g < NI; g++) begin
      mh[g] = 0; ms[g] = 0; mch[g] = 0; mst[g] = 0;
    end
    edge_n = 0;
  endtask

  task automatic m_edge();
    int e;
    e = edge_n + 1;
    for (int g = 0; g < NI; g++) begin
      bit ev, sk, acc, adv0;
      int idx;
      ev   = m_vo(g);
      sk   = m_skid(g);
      acc  = vin && m_rdy(g);
      adv0 = (mch[g] < dep_of(g)) || rin;
      if (flush) begin
        ms[g] = 0; mch[g] = 0;
      end else begin
        if (ev && !rin && mst[g] < (1 << cw_of(g)) - 1) mst[g]++;
        if (ev && rin) begin
          mh[g] = (mh[g] + 1) % 8; ms[g]--; mch[g]--;
        end
        if (sk && adv0) begin
          mt[g][m_tail(g)] = e; mch[g]++;
        end
        if (acc) begin
          idx = (mh[g] + ms[g]) % 8;
          md[g][idx] = din;
          mt[g][idx] = adv0 ? e : -1;
          ms[g]++;
          if (adv0) mch[g]++;
        end
      end
    end
    edge_n = e;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    vin = 1'b0; rin = 1'b0; flush = 1'b0; din = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    do_reset();
    for (int g = 0; g < NI; g++) begin
      nrun += 4;
      if (vo[g] !== 1'b0) begin
        nfail++; $display("FAIL reset_valid[%0d] got %b want 0", g, vo[g]);
      end
      if (occ[g] !== 4'd0) begin
        nfail++; $display("FAIL reset_occ[%0d] got %0d want 0", g, occ[g]);
      end
      if (stl[g] !== 16'd0) begin
        nfail++; $display("FAIL reset_stall[%0d] got %0d want 0", g, stl[g]);
      end
      if (rdy[g] !== 1'b1) begin
        nfail++; $display("FAIL reset_ready[%0d] got %b want 1", g, rdy[g]);
      end
    end
  endtask

  task automatic test_latency();
    logic [15:0] seq [3];
    bit          ev;
    seq[0] = 16'h000A; seq[1] = 16'h000B; seq[2] = 16'h000C;
    do_reset();
    rin = 1'b1;
    for (int i = 0; i < 6; i++) begin
      vin = (i < 3);
      din = (i < 3) ? seq[i] : 16'h0;
      tick();
      ev = (i >= 2 && i < 5);
      nrun++;
      if (vo[0] !== ev) begin
        nfail++; $display("FAIL lat_valid e%0d got %b want %b", i + 1, vo[0], ev);
      end
      if (ev) begin
        nrun++;
        if (dout[0] !== seq[i-2]) begin
          nfail++;
          $display("FAIL lat_data e%0d got %h want %h", i + 1, dout[0], seq[i-2]);
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      vin = 1'b1; din = 16'h0100 + 16'(i);
      tick();
    end
    vin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      nrun++;
      if (vo[1] !== 1'b1 || dout[1] !== 16'h0100) begin
        nfail++; $display("FAIL stall_hold v=%b d=%h want 1/0100", vo[1], dout[1]);
      end
    end
    nrun += 3;
    if (occ[1] !== 4'd3) begin
      nfail++; $display("FAIL stall_occ got %0d want 3", occ[1]);
    end
    if (rdy[1] !== 1'b0) begin
      nfail++; $display("FAIL stall_ready got %b want 0", rdy[1]);
    end
    if (stl[1] !== 16'd5) begin
      nfail++; $display("FAIL stall_cnt got %0d want 5", stl[1]);
    end
    rin = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      nrun++;
      if (i < 3 && (vo[1] !== 1'b1 || dout[1] !== 16'h0100 + 16'(i))) begin
        nfail++;
        $display("FAIL drain_data%0d got %b/%h want 1/%h", i, vo[1], dout[1], 16'h0100 + 16'(i));
      end
      if (i == 3 && vo[1] !== 1'b0) begin
        nfail++; $display("FAIL drain_empty got %b want 0", vo[1]);
      end
    end
    nrun++;
    if (rdy[1] !== 1'b1) begin
      nfail++; $display("FAIL drain_ready got %b want 1", rdy[1]);
    end
  endtask

  task automatic test_bubble();
    do_reset();
    rin = 1'b1; vin = 1'b1; din = 16'h00A1;
    tick();
    vin = 1'b0;
    tick();
    vin = 1'b1; din = 16'h00B2; rin = 1'b0;
    tick();
    vin = 1'b0;
    nrun += 2;
    if (vo[0] !== 1'b1 || dout[0] !== 16'h00A1) begin
      nfail++; $display("FAIL bub_head got %b/%h want 1/00a1", vo[0], dout[0]);
    end
    if (occ[0] !== 4'd2) begin
      nfail++; $display("FAIL bub_occ got %0d want 2", occ[0]);
    end
    tick();
    nrun++;
    if (rdy[0] !== 1'b1) begin
      nfail++; $display("FAIL bub_ready got %b want 1", rdy[0]);
    end
    rin = 1'b1;
    tick();
    nrun++;
    if (vo[0] !== 1'b1 || dout[0] !== 16'h00B2) begin
      nfail++; $display("FAIL bub_collapse got %b/%h want 1/00b2", vo[0], dout[0]);
    end
  endtask

  task automatic test_flush();
    do_reset();
    vin = 1'b1; din = 16'h0011;
    tick();
    din = 16'h0022;
    tick();
    nrun++;
    if (occ[0] !== 4'd2) begin
      nfail++; $display("FAIL flush_pre_occ got %0d want 2", occ[0]);
    end
    flush = 1'b1; din = 16'h0055;
    tick();
    flush = 1'b0; vin = 1'b0;
    for (int g = 0; g < NI; g++) begin
      nrun += 3;
      if (vo[g] !== 1'b0) begin
        nfail++; $display("FAIL flush_valid[%0d] got %b want 0", g, vo[g]);
      end
      if (occ[g] !== 4'd0) begin
        nfail++; $display("FAIL flush_occ[%0d] got %0d want 0", g, occ[g]);
      end
      if (rdy[g] !== 1'b1) begin
        nfail++; $display("FAIL flush_ready[%0d] got %b want 1", g, rdy[g]);
      end
    end
    nrun++;
    if (stl[1] !== 16'd0) begin
      nfail++; $display("FAIL flush_stall got %0d want 0", stl[1]);
    end
    rin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      for (int g = 0; g < NI; g++) begin
        nrun++;
        if (vo[g] !== 1'b0) begin
          nfail++; $display("FAIL flush_ghost[%0d] got %b/%h want 0", g, vo[g], dout[g]);
        end
      end
    end
  endtask

  task automatic test_saturate_async_reset();
    do_reset();
    vin = 1'b1; din = 16'h0077;
    tick();
    vin = 1'b0;
    repeat (11) tick();
    nrun += 2;
    if (stl[1] !== 16'd7) begin
      nfail++; $display("FAIL sat_cnt got %0d want 7", stl[1]);
    end
    if (stl[0] !== 16'd9) begin
      nfail++; $display("FAIL stall_cnt_d3 got %0d want 9", stl[0]);
    end
    #2 rst = 1'b1;
    #1;
    for (int g = 0; g < NI; g++) begin
      nrun += 4;
      if (vo[g] !== 1'b0) begin
        nfail++; $display("FAIL areset_valid[%0d] got %b want 0", g, vo[g]);
      end
      if (occ[g] !== 4'd0) begin
        nfail++; $display("FAIL areset_occ[%0d] got %0d want 0", g, occ[g]);
      end
      if (stl[g] !== 16'd0) begin
        nfail++; $display("FAIL areset_stall[%0d] got %0d want 0", g, stl[g]);
      end
      if (rdy[g] !== 1'b1) begin
        nfail++; $display("FAIL areset_ready[%0d] got %b want 1", g, rdy[g]);
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    vin = 1'b1; rin = 1'b1; din = 16'h0099;
    tick();
    vin = 1'b0;
    nrun++;
    if (occ[0] !== 4'd1) begin
      nfail++; $display("FAIL first_accept_occ got %0d want 1", occ[0]);
    end
  endtask

  task automatic test_random(input int ncyc);
    int lo;
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      lo    = ((c / 256) % 2 == 1) ? 20 : 80;
      vin   = ($urandom_range(0, 3) != 0);
      rin   = ($urandom_range(0, 99) < lo);
      flush = ($urandom_range(0, 31) == 0);
      din   = 16'($urandom);
      #1;
      for (int g = 0; g < NI; g++) begin
        nrun++;
        if (rdy[g] !== m_rdy(g)) begin
          nfail++; $display("FAIL rand_ready[%0d] c%0d got %b want %b", g, c, rdy[g], m_rdy(g));
        end
      end
      m_edge();
      tick();
      for (int g = 0; g < NI; g++) begin
        nrun += 3;
        if (vo[g] !== m_vo(g)) begin
          nfail++; $display("FAIL rand_valid[%0d] c%0d got %b want %b", g, c, vo[g], m_vo(g));
        end
        if (occ[g] !== 4'(ms[g])) begin
          nfail++; $display("FAIL rand_occ[%0d] c%0d got %0d want %0d", g, c, occ[g], ms[g]);
        end
        if (stl[g] !== 16'(mst[g])) begin
          nfail++; $display("FAIL rand_stall[%0d] c%0d got %0d want %0d", g, c, stl[g], mst[g]);
        end
        if (m_vo(g)) begin
          nrun++;
          if (dout[g] !== md[g][mh[g]]) begin
            nfail++;
            $display("FAIL rand_data[%0d] c%0d got %h want %h", g, c, dout[g], md[g][mh[g]]);
          end
        end
      end
    end
    flush = 1'b0;
  endtask

  initial begin
    nrun  = 0;
    nfail = 0;
    rst   = 1'b1;
    vin   = 1'b0;
    rin   = 1'b0;
    flush = 1'b0;
    din   = '0;
    test_reset();
    test_latency();
    test_stall();
    test_bubble();
    test_flush();
    test_saturate_async_reset();
    test_random(6000);
    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule
